mealy_stream_sequencer: RTL and testbench
=========================================

// Module: mealy_stream_sequencer
// PURPOSE
//  Feeds parallel words from an upstream valid/ready source, MSB first, one bit per clk, into
//  an embedded Mealy pattern detector (output depends on present bit plus stored history).
//  Counts detections per word, returns the count and a per-bit hit mask downstream.
//  Sequences the serial detector so word-oriented logic can share it without bit-level timing.
// PARAMETERS
//  WIDTH          8        bits per input word (>=2)
//  PAT_LEN        4        detected pattern length (2..WIDTH)
//  PATTERN        4'b1101  pattern; PATTERN[PAT_LEN-1] is the first bit in time
//  CLEAR_PER_WORD 1        1: detector history cleared at each word accept; 0: carried across words
// PORTS
//  clk        in   1                  system clock, rising edge
//  rst        in   1                  asynchronous, active-high reset
//  abort      in   1                  sync cancel of the word in flight / pending result
//  in_valid   in   1                  upstream word valid
//  in_ready   out  1                  block can accept a word (IDLE only)
//  in_data    in   WIDTH              word to scan, bit WIDTH-1 sent first
//  out_valid  out  1                  result valid
//  out_ready  in   1                  downstream accepts result
//  out_count  out  $clog2(WIDTH+1)    number of hits in the word
//  out_mask   out  WIDTH              out_mask[k]=1 iff a hit completed on in_data[k]
//  det_bit    out  1                  serial bit currently presented to detector (debug)
//  det_hit    out  1                  Mealy detector output, combinational, SHIFT only
//  busy       out  1                  state != IDLE
// BEHAVIOUR
//  - Reset (async): state=IDLE, shift reg, history, fill counter, bit index, out_count, out_mask
//    = 0; outputs in_ready=1, out_valid=0, det_bit=0, det_hit=0, busy=0.
//  - FSM states: IDLE, SHIFT, REPORT.
//  - IDLE: in_ready=1. in_valid&&!abort at edge E0: load in_data, idx=0, count=0, mask=0,
//    history/fill cleared if CLEAR_PER_WORD=1 -> SHIFT.
//  - SHIFT: in_ready=0; det_bit=shreg[WIDTH-1]. Each edge: shift left, history<=
//    {history[PAT_LEN-2:0],det_bit}, fill<=min(fill+1,PAT_LEN), idx++.
//    det_hit = (fill>=PAT_LEN-1) && ({history[PAT_LEN-2:0],det_bit}==PATTERN).
//    On hit at idx i: count++, mask[WIDTH-1-i]<=1. Overlapping matches count.
//    Edge with idx==WIDTH-1 -> REPORT (word occupies exactly WIDTH SHIFT cycles).
//  - fill guard: no hit until PAT_LEN bits are seen since last clear (e.g. all-zero pattern
//    after reset does not fire on cleared history).
//  - REPORT: out_valid=1, out_count/out_mask stable until out_valid&&out_ready edge -> IDLE.
//    Latency: accept at E0 -> out_valid high after edge E_WIDTH; min throughput 1 word per
//    WIDTH+2 cycles with out_ready held high.
//  - out_count/out_mask hold last reported value in IDLE. They are cleared at the next accept.
//  - abort (SHIFT or REPORT): next edge -> IDLE; no out_valid for that word; history and fill
//    cleared regardless of CLEAR_PER_WORD. abort in IDLE: no accept that cycle.
//  - abort has priority over in_valid, out_ready and shift progression.
//  - in_valid while not IDLE is ignored (in_ready=0); in_data sampled only at accept edge.
//  - Async rst mid-SHIFT/REPORT: immediate return to reset values; pending word lost.
//  - Count cannot overflow: max hits <= WIDTH fits $clog2(WIDTH+1) bits.
// TESTING  (WIDTH=8, PAT_LEN=4, PATTERN=4'b1101 unless noted; out_ready=1)
//  1 rst pulse, then in_data=8'hDA (1101_1010) -> out_count=2, out_mask=8'b0001_0010,
//    out_valid 8 edges after accept, high 1 cycle.
//  2 overlap: in_data=8'b1101_1101 -> out_count=2, out_mask=8'b0001_0001;
//    in_data=8'h00 -> count=0, mask=0.
//  3 CLEAR_PER_WORD=0: 8'b0000_0110 then 8'b1000_0000 -> 2nd word count=1, mask=8'b1000_0000;
//    same with CLEAR_PER_WORD=1 -> count=0.
//  4 backpressure: out_ready=0 for 5 cycles in REPORT -> out_valid, count, mask stable,
//    in_ready=0; release -> IDLE next edge, next word accepted.
//  5 abort at 3rd SHIFT cycle -> IDLE next edge, no out_valid; following 8'hDA -> count=2.
//    PATTERN=4'b0000, word 8'h0F right after reset -> count=1, mask=8'b0001_0000 (fill guard).
//  6 async rst asserted mid-SHIFT (between edges) -> all outputs at reset values immediately;
//    in_valid during SHIFT -> never accepted.

Source files
------------

// File: rtl/mealy_stream_sequencer.sv
// mealy_stream_sequencer
// Serialises accepted words MSB first into an embedded Mealy pattern detector,
// collects the hit count and a per-bit hit mask, and returns them to a
// valid/ready downstream. States: IDLE (accept), SHIFT (one bit per clock),
// REPORT (hold result until taken). abort cancels any word in flight.
module mealy_stream_sequencer #(
    parameter int                 WIDTH          = 8,
    parameter int                 PAT_LEN        = 4,
    parameter logic [PAT_LEN-1:0] PATTERN        = 4'b1101,
    parameter bit                 CLEAR_PER_WORD = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       abort,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(WIDTH+1)-1:0] out_count,
    output logic [WIDTH-1:0]           out_mask,
    output logic                       det_bit,
    output logic                       det_hit,
    output logic                       busy
);

    localparam int IDX_W  = $clog2(WIDTH);
    localparam int FILL_W = $clog2(PAT_LEN + 1);
    localparam int CNT_W  = $clog2(WIDTH + 1);

    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(WIDTH - 1);
    localparam logic [FILL_W-1:0] FILL_MAX  = FILL_W'(PAT_LEN);
    localparam logic [FILL_W-1:0] FILL_HIT  = FILL_W'(PAT_LEN - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SHIFT  = 2'b01,
        REPORT = 2'b10
    } state_t;

    state_t               state_r;
    state_t               state_next_s;
    logic [WIDTH-1:0]     shreg_r;
    logic [WIDTH-1:0]     shreg_next_s;
    logic [PAT_LEN-2:0]   hist_r;
    logic [PAT_LEN-2:0]   hist_next_s;
    logic [FILL_W-1:0]    fill_r;
    logic [FILL_W-1:0]    fill_next_s;
    logic [IDX_W-1:0]     idx_r;
    logic [IDX_W-1:0]     idx_next_s;
    logic [CNT_W-1:0]     count_r;
    logic [CNT_W-1:0]     count_next_s;
    logic [WIDTH-1:0]     mask_r;
    logic [WIDTH-1:0]     mask_next_s;
    logic                 in_ready_r;
    logic                 out_valid_r;
    logic                 busy_r;

    logic                 det_bit_s;
    logic                 det_hit_s;
    logic [PAT_LEN-1:0]   window_s;
    logic [WIDTH-1:0]     hit_onehot_s;

    // Mealy detector: present serial bit plus stored history, gated by the fill guard
    always_comb begin
        det_bit_s    = 1'b0;
        det_hit_s    = 1'b0;
        hit_onehot_s = {WIDTH{1'b0}};
        if (state_r == SHIFT) begin
            det_bit_s = shreg_r[WIDTH-1];
        end else begin
            det_bit_s = 1'b0;
        end
        window_s = {hist_r, det_bit_s};
        if ((state_r == SHIFT) && (fill_r >= FILL_HIT) && (window_s == PATTERN)) begin
            det_hit_s = 1'b1;
        end else begin
            det_hit_s = 1'b0;
        end
        // bit index i was in_data[WIDTH-1-i] when the word was loaded
        hit_onehot_s[LAST_IDX - idx_r] = 1'b1;
    end

    // Next-state and datapath update; abort outranks every other request
    always_comb begin
        state_next_s = state_r;
        shreg_next_s = shreg_r;
        hist_next_s  = hist_r;
        fill_next_s  = fill_r;
        idx_next_s   = idx_r;
        count_next_s = count_r;
        mask_next_s  = mask_r;
        case (state_r)
            IDLE: begin
                if (abort) begin
                    state_next_s = IDLE;
                end else if (in_valid) begin
                    state_next_s = SHIFT;
                    shreg_next_s = in_data;
                    idx_next_s   = {IDX_W{1'b0}};
                    count_next_s = {CNT_W{1'b0}};
                    mask_next_s  = {WIDTH{1'b0}};
                    if (CLEAR_PER_WORD) begin
                        hist_next_s = {(PAT_LEN-1){1'b0}};
                        fill_next_s = {FILL_W{1'b0}};
                    end else begin
                        hist_next_s = hist_r;
                        fill_next_s = fill_r;
                    end
                end else begin
                    state_next_s = IDLE;
                end
            end
            SHIFT: begin
                if (abort) begin
                    state_next_s = IDLE;
                    hist_next_s  = {(PAT_LEN-1){1'b0}};
                    fill_next_s  = {FILL_W{1'b0}};
                end else begin
                    shreg_next_s = {shreg_r[WIDTH-2:0], 1'b0};
                    hist_next_s  = window_s[PAT_LEN-2:0];
                    if (fill_r < FILL_MAX) begin
                        fill_next_s = fill_r + FILL_W'(1);
                    end else begin
                        fill_next_s = fill_r;
                    end
                    if (det_hit_s) begin
                        count_next_s = count_r + CNT_W'(1);
                        mask_next_s  = mask_r | hit_onehot_s;
                    end else begin
                        count_next_s = count_r;
                        mask_next_s  = mask_r;
                    end
                    if (idx_r == LAST_IDX) begin
                        state_next_s = REPORT;
                        idx_next_s   = {IDX_W{1'b0}};
                    end else begin
                        state_next_s = SHIFT;
                        idx_next_s   = idx_r + IDX_W'(1);
                    end
                end
            end
            REPORT: begin
                if (abort) begin
                    state_next_s = IDLE;
                    hist_next_s  = {(PAT_LEN-1){1'b0}};
                    fill_next_s  = {FILL_W{1'b0}};
                end else if (out_ready) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = REPORT;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Datapath registers and registered handshake/status flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg_r     <= {WIDTH{1'b0}};
            hist_r      <= {(PAT_LEN-1){1'b0}};
            fill_r      <= {FILL_W{1'b0}};
            idx_r       <= {IDX_W{1'b0}};
            count_r     <= {CNT_W{1'b0}};
            mask_r      <= {WIDTH{1'b0}};
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            shreg_r     <= shreg_next_s;
            hist_r      <= hist_next_s;
            fill_r      <= fill_next_s;
            idx_r       <= idx_next_s;
            count_r     <= count_next_s;
            mask_r      <= mask_next_s;
            in_ready_r  <= (state_next_s == IDLE);
            out_valid_r <= (state_next_s == REPORT);
            busy_r      <= (state_next_s != IDLE);
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign busy      = busy_r;
    assign out_count = count_r;
    assign out_mask  = mask_r;
    assign det_bit   = det_bit_s;
    assign det_hit   = det_hit_s;

endmodule

// File: tb/tb_mealy_stream_sequencer.sv
// Directed bench for mealy_stream_sequencer: three instances share the input
// stimulus (default, carried history, all-zero pattern) and run in lockstep.
module tb_mealy_stream_sequencer;

    logic       clk;
    logic       rst;
    logic       abort;
    logic       in_valid;
    logic [7:0] in_data;
    logic       out_ready;

    logic       in_ready,  out_valid,  det_bit,  det_hit,  busy;
    logic [3:0] out_count;
    logic [7:0] out_mask;
    logic       nc_in_ready, nc_out_valid, nc_det_bit, nc_det_hit, nc_busy;
    logic [3:0] nc_out_count;
    logic [7:0] nc_out_mask;
    logic       z_in_ready, z_out_valid, z_det_bit, z_det_hit, z_busy;
    logic [3:0] z_out_count;
    logic [7:0] z_out_mask;

    int checks;
    int failures;

    mealy_stream_sequencer u_dut (
        .clk(clk), .rst(rst), .abort(abort), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_count(out_count), .out_mask(out_mask), .det_bit(det_bit),
        .det_hit(det_hit), .busy(busy)
    );

    mealy_stream_sequencer #(.CLEAR_PER_WORD(1'b0)) u_nc (
        .clk(clk), .rst(rst), .abort(abort), .in_valid(in_valid), .in_ready(nc_in_ready),
        .in_data(in_data), .out_valid(nc_out_valid), .out_ready(out_ready),
        .out_count(nc_out_count), .out_mask(nc_out_mask), .det_bit(nc_det_bit),
        .det_hit(nc_det_hit), .busy(nc_busy)
    );

    mealy_stream_sequencer #(.PATTERN(4'b0000)) u_z (
        .clk(clk), .rst(rst), .abort(abort), .in_valid(in_valid), .in_ready(z_in_ready),
        .in_data(in_data), .out_valid(z_out_valid), .out_ready(out_ready),
        .out_count(z_out_count), .out_mask(z_out_mask), .det_bit(z_det_bit),
        .det_hit(z_det_hit), .busy(z_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Accept one word, check every SHIFT cycle, the REPORT cycle and the return to IDLE
    task automatic run_word(input string tag, input logic [7:0] data,
                            input logic [3:0] exp_count, input logic [7:0] exp_mask);
        check({tag, "_ready_before"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_data  = data;
        step();
        in_valid = 1'b0;
        for (int j = 0; j < 8; j++) begin
            check({tag, "_det_bit"}, 32'(det_bit), 32'(data[7-j]));
            check({tag, "_det_hit"}, 32'(det_hit), 32'(exp_mask[7-j]));
            check({tag, "_no_valid"}, 32'(out_valid), 32'd0);
            step();
        end
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_count"}, 32'(out_count), 32'(exp_count));
        check({tag, "_mask"}, 32'(out_mask), 32'(exp_mask));
        step();
        check({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
        check({tag, "_ready_after"}, 32'(in_ready), 32'd1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst       = 1'b1;
        abort     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b1;
        step();
        step();
        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy",      32'(busy),      32'd0);
        check("rst_det_bit",   32'(det_bit),   32'd0);
        check("rst_det_hit",   32'(det_hit),   32'd0);
        check("rst_count",     32'(out_count), 32'd0);
        check("rst_mask",      32'(out_mask),  32'd0);
        rst = 1'b0;
        step();

        // basic word and overlapping matches
        run_word("t1_da", 8'hDA, 4'd2, 8'b0001_0010);
        check("t1_hold_count", 32'(out_count), 32'd2);
        run_word("t2_dd", 8'hDD, 4'd2, 8'b0001_0001);
        run_word("t2_00", 8'h00, 4'd0, 8'b0000_0000);

        // history carried across words only in the CLEAR_PER_WORD=0 instance
        do_reset();
        run_word("t3_06", 8'h06, 4'd0, 8'b0000_0000);
        run_word("t3_80", 8'h80, 4'd0, 8'b0000_0000);
        check("t3_nc_count", 32'(nc_out_count), 32'd1);
        check("t3_nc_mask",  32'(nc_out_mask),  32'h80);

        // backpressure in REPORT, in_valid ignored meanwhile
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'hDA;
        step();
        in_data   = 8'hFF;
        for (int j = 0; j < 8; j++) step();
        for (int j = 0; j < 5; j++) begin
            check("t4_valid_hold", 32'(out_valid), 32'd1);
            check("t4_count_hold", 32'(out_count), 32'd2);
            check("t4_mask_hold",  32'(out_mask),  32'h12);
            check("t4_in_ready",   32'(in_ready),  32'd0);
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        check("t4_release_valid", 32'(out_valid), 32'd0);
        check("t4_release_ready", 32'(in_ready),  32'd1);
        run_word("t4_next", 8'hDD, 4'd2, 8'b0001_0001);

        // abort in IDLE blocks the accept
        abort    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'hDA;
        step();
        check("t5_idle_abort_busy",  32'(busy),     32'd0);
        check("t5_idle_abort_ready", 32'(in_ready), 32'd1);
        abort    = 1'b0;
        step();
        in_valid = 1'b0;
        // abort during the third SHIFT cycle
        for (int j = 0; j < 2; j++) step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("t5_abort_idle",  32'(in_ready), 32'd1);
        check("t5_abort_busy",  32'(busy),     32'd0);
        for (int j = 0; j < 10; j++) begin
            check("t5_abort_no_valid", 32'(out_valid), 32'd0);
            step();
        end
        run_word("t5_after", 8'hDA, 4'd2, 8'b0001_0010);

        // fill guard with all-zero pattern right after reset
        do_reset();
        run_word("t5_0f", 8'h0F, 4'd0, 8'b0000_0000);
        check("t5_z_count", 32'(z_out_count), 32'd1);
        check("t5_z_mask",  32'(z_out_mask),  32'h10);

        // async reset mid-SHIFT
        in_valid = 1'b1;
        in_data  = 8'hDA;
        step();
        in_valid = 1'b0;
        for (int j = 0; j < 5; j++) step();
        check("t6_pre_count", 32'(out_count), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("t6_rst_ready", 32'(in_ready),  32'd1);
        check("t6_rst_busy",  32'(busy),      32'd0);
        check("t6_rst_valid", 32'(out_valid), 32'd0);
        check("t6_rst_bit",   32'(det_bit),   32'd0);
        check("t6_rst_hit",   32'(det_hit),   32'd0);
        check("t6_rst_count", 32'(out_count), 32'd0);
        check("t6_rst_mask",  32'(out_mask),  32'd0);
        step();
        rst = 1'b0;
        step();

        // in_valid held through SHIFT with other data is never taken
        in_valid = 1'b1;
        in_data  = 8'h00;
        step();
        in_data  = 8'hDA;
        for (int j = 0; j < 8; j++) begin
            check("t6_shift_not_ready", 32'(in_ready),  32'd0);
            check("t6_shift_no_valid",  32'(out_valid), 32'd0);
            step();
        end
        in_valid = 1'b0;
        check("t6_word_valid", 32'(out_valid), 32'd1);
        check("t6_word_count", 32'(out_count), 32'd0);
        check("t6_word_mask",  32'(out_mask),  32'd0);
        step();
        check("t6_word_idle", 32'(in_ready), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
